run_bench_ctrl: RTL and testbench

RUN_BENCH_CTRL -- requirements
Module: run_bench_ctrl

---
 rtl/run_bench_ctrl.sv | 139 +++++++++++++
 tb/tb_run_bench_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_bench_ctrl.sv
// Benchmark sequencer: issues back-to-back DUT start pulses, times each run
// from start to ready rising edge, and keeps last/min/max/total latency stats.
module run_bench_ctrl #(
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 32,
    parameter int RUNS_W  = 8,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [RUNS_W-1:0] num_runs,
    output logic              dut_start,
    input  logic              dut_ready,
    input  logic [DATA_W-1:0] dut_data,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [RUNS_W-1:0] run_idx,
    output logic [CNT_W-1:0]  last_cycles,
    output logic [CNT_W-1:0]  min_cycles,
    output logic [CNT_W-1:0]  max_cycles,
    output logic [CNT_W-1:0]  total_cycles,
    output logic [DATA_W-1:0] last_data
);

    typedef enum logic [2:0] {IDLE, START, WAIT, GAP, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    lat;
    logic [RUNS_W-1:0]   runs;
    logic [RUNS_W:0]     idx_inc;
    logic                ready_q;
    logic                rise;
    logic                expire;
    logic                more;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a);
        return (a == CNT_MAX) ? a : a + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
    endfunction

    // The counter holds edges-1 during WAIT, so the latency of this edge is cnt+1.
    assign lat     = sat_inc(cnt);
    assign rise    = dut_ready & ~ready_q;
    assign expire  = (TIMEOUT != 0) && (lat >= TO_LIM);
    assign idx_inc = {1'b0, run_idx} + {{RUNS_W{1'b0}}, 1'b1};
    assign more    = idx_inc < {1'b0, runs};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        dut_start = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (go) state_nxt = START;
            end
            START: begin
                dut_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (rise)        state_nxt = more ? GAP : DONE;
                else if (expire) state_nxt = DONE;
            end
            GAP:  state_nxt = START;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q      <= 1'b0;
            cnt          <= '0;
            runs         <= '0;
            run_idx      <= '0;
            timeout_err  <= 1'b0;
            last_cycles  <= '0;
            min_cycles   <= '0;
            max_cycles   <= '0;
            total_cycles <= '0;
            last_data    <= '0;
        end else begin
            ready_q <= dut_ready;
            case (state)
                IDLE: begin
                    if (go) begin
                        runs         <= (num_runs == '0) ? {{(RUNS_W-1){1'b0}}, 1'b1} : num_runs;
                        run_idx      <= '0;
                        timeout_err  <= 1'b0;
                        last_cycles  <= '0;
                        min_cycles   <= '0;
                        max_cycles   <= '0;
                        total_cycles <= '0;
                        last_data    <= '0;
                    end
                end
                START: cnt <= '0;
                WAIT: begin
                    cnt <= lat;
                    // Completion takes priority over a timeout on the same edge.
                    if (rise) begin
                        last_cycles  <= lat;
                        last_data    <= dut_data;
                        total_cycles <= sat_add(total_cycles, lat);
                        if (run_idx == '0 || lat < min_cycles) min_cycles <= lat;
                        if (run_idx == '0 || lat > max_cycles) max_cycles <= lat;
                        if (more) run_idx <= idx_inc[RUNS_W-1:0];
                    end else if (expire) begin
                        timeout_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_run_bench_ctrl.sv
// Scoreboard bench for run_bench_ctrl: a responder raises dut_ready after a
// chosen latency, expected statistics are queued at go and checked at done.
module tb_run_bench_ctrl;

    localparam int DW = 32;
    localparam int CW = 32;
    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          go = 1'b0;
    logic [RW-1:0] num_runs = '0;
    logic          dut_ready = 1'b0;
    logic [DW-1:0] dut_data = '0;

    logic          dut_start, busy, done, timeout_err;
    logic [RW-1:0] run_idx;
    logic [CW-1:0] last_cycles, min_cycles, max_cycles, total_cycles;
    logic [DW-1:0] last_data;

    logic          u2_start, u2_busy, u2_done, u2_terr;
    logic [RW-1:0] u2_idx;
    logic [3:0]    u2_last, u2_min, u2_max, u2_total;
    logic [DW-1:0] u2_data;

    run_bench_ctrl #(.DATA_W(DW), .CNT_W(CW), .RUNS_W(RW), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .go(go), .num_runs(num_runs), .dut_start(dut_start),
        .dut_ready(dut_ready), .dut_data(dut_data), .busy(busy), .done(done),
        .timeout_err(timeout_err), .run_idx(run_idx), .last_cycles(last_cycles),
        .min_cycles(min_cycles), .max_cycles(max_cycles), .total_cycles(total_cycles),
        .last_data(last_data)
    );

    run_bench_ctrl #(.DATA_W(DW), .CNT_W(4), .RUNS_W(RW), .TIMEOUT(0)) dut_sat (
        .clk(clk), .rst(rst), .go(go), .num_runs(num_runs), .dut_start(u2_start),
        .dut_ready(dut_ready), .dut_data(dut_data), .busy(u2_busy), .done(u2_done),
        .timeout_err(u2_terr), .run_idx(u2_idx), .last_cycles(u2_last),
        .min_cycles(u2_min), .max_cycles(u2_max), .total_cycles(u2_total),
        .last_data(u2_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] last, mn, mx, total;
        logic [RW-1:0] idx;
        logic [DW-1:0] data;
        logic          terr;
    } exp_t;

    exp_t sb[$];
    int   lat[$];
    int   checks = 0;
    int   failures = 0;

    function automatic logic [DW-1:0] data_for(input int r, input int k);
        return 32'hA500_0000 ^ DW'(r << 8) ^ DW'(k);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expect(input int nr, input bit terr);
        exp_t e;
        int   runs;
        runs = (nr == 0) ? 1 : nr;
        e = '{last: '0, mn: '0, mx: '0, total: '0, idx: '0, data: '0, terr: terr};
        if (!terr) begin
            e.mn = CW'(lat[0]);
            e.mx = CW'(lat[0]);
            for (int r = 0; r < runs; r++) begin
                if (CW'(lat[r]) < e.mn) e.mn = CW'(lat[r]);
                if (CW'(lat[r]) > e.mx) e.mx = CW'(lat[r]);
                e.total = e.total + CW'(lat[r]);
            end
            e.last = CW'(lat[runs-1]);
            e.idx  = RW'(runs - 1);
            e.data = data_for(runs - 1, lat[runs-1]);
        end
        sb.push_back(e);
    endtask

    // Waits for a start pulse; the number of idle cycles seen is returned.
    task automatic wait_start(output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        for (int i = 0; i < 64; i++) begin
            if (dut_start) begin
                ok = 1'b1;
                return;
            end
            waited++;
            tick();
        end
        checks++;
        failures++;
        $display("FAIL start_wait: no dut_start within 64 cycles");
    endtask

    // One run with latency k; returns positioned just after the completion edge.
    task automatic do_run(input int r, input int k, input bit stuck_prev,
                          input bit hold, input bit poke_go, output bit ok);
        int waited;
        wait_start(ok, waited);
        if (!ok) return;
        checks++;
        if (waited !== (r == 0 ? 0 : 1)) begin
            failures++;
            $display("FAIL start_spacing run=%0d: idle=%0d want=%0d", r, waited, (r == 0 ? 0 : 1));
        end
        dut_data = data_for(r, k);
        tick();
        checks++;
        if (dut_start !== 1'b0) begin
            failures++;
            $display("FAIL start_width run=%0d: dut_start=%b want=0", r, dut_start);
        end
        for (int e = 0; e < k; e++) begin
            if (poke_go && e == 0) begin go = 1'b1; num_runs = 8'd5; end
            if (poke_go && e == 1) begin go = 1'b0; num_runs = 8'hFF; end
            if (stuck_prev && e == 1) dut_ready = 1'b0;
            if (e == k - 1) dut_ready = 1'b1;
            tick();
        end
        if (!hold) dut_ready = 1'b0;
    endtask

    task automatic run_seq(input int nr, input bit stuck, input int poke_run);
        exp_t e;
        bit   ok;
        int   runs;
        runs = (nr == 0) ? 1 : nr;
        push_expect(nr, 1'b0);
        num_runs = RW'(nr);
        go = 1'b1;
        tick();
        go = 1'b0;
        num_runs = 8'hFF;
        for (int r = 0; r < runs; r++) begin
            do_run(r, lat[r], stuck && r > 0, stuck, poke_run == r, ok);
            if (!ok) return;
        end
        dut_ready = 1'b0;
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL done_pulse: done=%b busy=%b want done=1 busy=1", done, busy);
        end
        checks++;
        if (last_cycles !== e.last) begin
            failures++;
            $display("FAIL last_cycles: got %0d want %0d", last_cycles, e.last);
        end
        checks++;
        if (min_cycles !== e.mn || max_cycles !== e.mx) begin
            failures++;
            $display("FAIL min_max: got %0d/%0d want %0d/%0d", min_cycles, max_cycles, e.mn, e.mx);
        end
        checks++;
        if (total_cycles !== e.total) begin
            failures++;
            $display("FAIL total_cycles: got %0d want %0d", total_cycles, e.total);
        end
        checks++;
        if (run_idx !== e.idx || last_data !== e.data || timeout_err !== e.terr) begin
            failures++;
            $display("FAIL idx_data_terr: got %0d/%h/%b want %0d/%h/%b",
                     run_idx, last_data, timeout_err, e.idx, e.data, e.terr);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL done_end: done=%b busy=%b want 0/0", done, busy);
        end
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || last_cycles !== e.last || total_cycles !== e.total) begin
            failures++;
            $display("FAIL idle_hold: busy=%b last=%0d total=%0d want 0/%0d/%0d",
                     busy, last_cycles, total_cycles, e.last, e.total);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy, done, dut_start, timeout_err} !== 4'b0 || run_idx !== '0 ||
            last_cycles !== '0 || min_cycles !== '0 || max_cycles !== '0 ||
            total_cycles !== '0 || last_data !== '0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b start=%b min=%0d total=%0d want all 0",
                     busy, done, dut_start, min_cycles, total_cycles);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        lat = '{5};
        run_seq(1, 1'b0, -1);
    endtask

    task automatic test_multi_run();
        lat = '{4, 9, 6};
        run_seq(3, 1'b0, 1);
    endtask

    task automatic test_stuck_ready();
        lat = '{3, 7, 5};
        run_seq(3, 1'b1, -1);
    endtask

    task automatic test_zero_runs();
        lat = '{2};
        run_seq(0, 1'b0, -1);
    endtask

    task automatic test_timeout_boundary();
        lat = '{16};
        run_seq(1, 1'b0, -1);
    endtask

    task automatic test_saturation();
        lat = '{12, 10};
        run_seq(2, 1'b0, -1);
        checks++;
        if (u2_total !== 4'd15 || u2_last !== 4'd10 || u2_min !== 4'd10 || u2_max !== 4'd12) begin
            failures++;
            $display("FAIL sat_total: total=%0d last=%0d min=%0d max=%0d want 15/10/10/12",
                     u2_total, u2_last, u2_min, u2_max);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        bit   ok;
        int   waited;
        lat = '{0};
        push_expect(1, 1'b1);
        num_runs = 8'd1;
        go = 1'b1;
        tick();
        go = 1'b0;
        wait_start(ok, waited);
        if (!ok) return;
        repeat (16) tick();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early: busy=%b done=%b at edge 15 want 1/0", busy, done);
        end
        tick();
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1 || timeout_err !== e.terr) begin
            failures++;
            $display("FAIL timeout_done: done=%b terr=%b want 1/%b", done, timeout_err, e.terr);
        end
        checks++;
        if (last_cycles !== e.last || min_cycles !== e.mn || max_cycles !== e.mx ||
            total_cycles !== e.total || run_idx !== e.idx) begin
            failures++;
            $display("FAIL timeout_stats: last=%0d min=%0d max=%0d total=%0d idx=%0d want cleared",
                     last_cycles, min_cycles, max_cycles, total_cycles, run_idx);
        end
        repeat (2) tick();
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_sticky: terr=%b busy=%b want 1/0", timeout_err, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int waited;
        int seen_done;
        num_runs = 8'd2;
        go = 1'b1;
        tick();
        go = 1'b0;
        wait_start(ok, waited);
        if (!ok) return;
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, dut_start, timeout_err} !== 4'b0 || run_idx !== '0 ||
            last_cycles !== '0 || min_cycles !== '0 || max_cycles !== '0 ||
            total_cycles !== '0 || last_data !== '0) begin
            failures++;
            $display("FAIL reset_mid: busy=%b done=%b terr=%b min=%0d want all 0",
                     busy, done, timeout_err, min_cycles);
        end
        tick();
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || busy || dut_start) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            failures++;
            $display("FAIL reset_no_done: active cycles=%0d want 0", seen_done);
        end
        lat = '{7};
        run_seq(1, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_run();
        test_stuck_ready();
        test_zero_runs();
        test_saturation();
        test_timeout_boundary();
        test_timeout();
        test_single();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
